// File: rtl/debug_slave_cmd_sync.sv
// Purpose: carry JTAG update-DR commands {ir, sr} from the TCK domain into clk, queue them, and decode each pop into one-hot action pulses.
// Latency: udr rise -> cmd_valid is SYNC_STAGES+2 clks; pop -> take_action/take_no_action is 1 clk; uir rise -> ir_change is SYNC_STAGES+1 clks.
// Backpressure: cmd_ready low holds the head stable; new commands are dropped into the sticky overflow flag when the queue is full.
module debug_slave_cmd_sync #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [SR_WIDTH-1:0]           sr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_WIDTH-1:0]           cmd_ir,
    output logic [SR_WIDTH-1:0]           cmd_data,
    output logic [(2**IR_WIDTH)-1:0]      take_action,
    output logic [(2**IR_WIDTH)-1:0]      take_no_action,
    output logic                          ir_change,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int CW  = IR_WIDTH + SR_WIDTH;
    localparam int NCH = 2 ** IR_WIDTH;

    // Synchronizers, edge history and arming delay
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic                   udr_hist_q;
    logic                   uir_hist_q;
    logic                   udr_rise_q;
    logic                   uir_rise_q;
    logic [SYNC_STAGES:0]   arm_q;
    logic                   armed;

    // Command queue state
    logic [CW-1:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic [NCH-1:0]         take_action_q, take_action_d;
    logic [NCH-1:0]         take_no_action_q, take_no_action_d;

    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [NCH-1:0]         head_onehot;

    // Edges that reach the end of the chain before armed are treated as reset leftovers.
    assign armed = arm_q[SYNC_STAGES];

    // Synchronize the TCK-domain levels and register single-cycle rise pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q <= '0;
            uir_sync_q <= '0;
            udr_hist_q <= 1'b0;
            uir_hist_q <= 1'b0;
            udr_rise_q <= 1'b0;
            uir_rise_q <= 1'b0;
            arm_q      <= '0;
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
            uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
            udr_rise_q <= udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q & armed;
            uir_rise_q <= uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q & armed;
            arm_q      <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // The head is read straight from registered storage, so it only moves on a pop.
    assign cmd_valid   = (level_q != '0);
    assign {cmd_ir, cmd_data} = mem_q[rd_ptr_q];
    assign full        = (level_q == LW'(FIFO_DEPTH));
    assign pop         = cmd_valid & cmd_ready;
    // A pop in the same cycle frees the slot the write lands in, so a full queue still accepts.
    assign push        = udr_rise_q & (~full | pop);
    assign drop        = udr_rise_q & full & ~pop;
    assign head_onehot = {{(NCH-1){1'b0}}, 1'b1} << cmd_ir;

    // Next-state for pointers, level, sticky overflow and the decode pulses.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        level_d          = level_q + LW'(push) - LW'(pop);
        overflow_d       = drop | (overflow_q & ~clear_overflow);
        take_action_d    = '0;
        take_no_action_d = '0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (cmd_data[SR_WIDTH-1]) begin
                take_action_d = head_onehot;
            end else begin
                take_no_action_d = head_onehot;
            end
        end
    end

    // Queue storage and control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            overflow_q       <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {ir_in, sr};
            end
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            overflow_q       <= overflow_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
        end
    end

    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign ir_change      = uir_rise_q;
    assign overflow       = overflow_q;
    assign fifo_level     = level_q;

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Bench for debug_slave_cmd_sync: queue-based reference model plus directed and random stimulus.
// Inputs change on the falling edge; outputs are compared on every falling edge while out of reset.
// Literal expectations pin the model for the single-command, fill, full+pop, decode and reset cases.
module tb_debug_slave_cmd_sync;

    localparam int SR = 38;
    localparam int IR = 2;
    localparam int S  = 2;
    localparam int D  = 4;

    logic          clk;
    logic          reset_n;
    logic          vs_udr;
    logic          vs_uir;
    logic [IR-1:0] ir_in;
    logic [SR-1:0] sr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IR-1:0] cmd_ir;
    logic [SR-1:0] cmd_data;
    logic [3:0]    take_action;
    logic [3:0]    take_no_action;
    logic          ir_change;
    logic          overflow;
    logic          clear_overflow;
    logic [2:0]    fifo_level;

    debug_slave_cmd_sync #(
        .SR_WIDTH(SR), .IR_WIDTH(IR), .SYNC_STAGES(S), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .take_action(take_action),
        .take_no_action(take_no_action), .ir_change(ir_change), .overflow(overflow),
        .clear_overflow(clear_overflow), .fifo_level(fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [SR-1:0] rand38();
        return SR'({$urandom(), $urandom()});
    endfunction

    // ---------------- reference model ----------------
    // An input rise first seen on clock edge j (j>=2 after release) becomes a push on edge j+S+1
    // and an ir_change pulse after edge j+S; everything else is queue bookkeeping.
    logic [IR+SR-1:0] m_q[$];
    int               push_at[$];
    int               irc_at[$];
    int               edge_cnt;
    logic             udr_last, uir_last;
    logic             m_ovf, m_irc;
    logic [3:0]       m_ta, m_tna;

    task automatic model_step();
        logic             do_push, do_pop, is_full, set_ovf;
        logic [IR+SR-1:0] h;
        if (!reset_n) begin
            m_q.delete(); push_at.delete(); irc_at.delete();
            edge_cnt = 0; udr_last = 1'b0; uir_last = 1'b0;
            m_ovf = 1'b0; m_irc = 1'b0; m_ta = '0; m_tna = '0;
            return;
        end
        edge_cnt++;
        do_push = 1'b0;
        if (push_at.size() > 0 && push_at[0] == edge_cnt) begin
            do_push = 1'b1;
            void'(push_at.pop_front());
        end
        m_irc = 1'b0;
        if (irc_at.size() > 0 && irc_at[0] == edge_cnt) begin
            m_irc = 1'b1;
            void'(irc_at.pop_front());
        end
        if (vs_udr && !udr_last && edge_cnt >= 2) push_at.push_back(edge_cnt + S + 1);
        if (vs_uir && !uir_last && edge_cnt >= 2) irc_at.push_back(edge_cnt + S);
        udr_last = vs_udr;
        uir_last = vs_uir;
        do_pop = (m_q.size() > 0) && cmd_ready;
        m_ta = '0;
        m_tna = '0;
        if (do_pop) begin
            h = m_q[0];
            if (h[SR-1]) m_ta[h[IR+SR-1:SR]] = 1'b1;
            else         m_tna[h[IR+SR-1:SR]] = 1'b1;
        end
        is_full = (m_q.size() == D);
        set_ovf = do_push && is_full && !do_pop;
        m_ovf   = set_ovf || (m_ovf && !clear_overflow);
        if (do_pop) void'(m_q.pop_front());
        if (do_push && !set_ovf) m_q.push_back({ir_in, sr});
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            model_step();
        end
    end

    task automatic compare();
        logic [IR+SR-1:0] h;
        chk("cmd_valid", 64'(cmd_valid), 64'(m_q.size() > 0));
        chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        if (m_q.size() > 0) begin
            h = m_q[0];
            chk("cmd_ir", 64'(cmd_ir), 64'(h[IR+SR-1:SR]));
            chk("cmd_data", 64'(cmd_data), 64'(h[SR-1:0]));
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("take_action", 64'(take_action), 64'(m_ta));
        chk("take_no_action", 64'(take_no_action), 64'(m_tna));
        chk("ir_change", 64'(ir_change), 64'(m_irc));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && chk_en) compare();
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers (called on a falling edge) ----------------
    task automatic udr_pulse(input logic [IR-1:0] ir, input logic [SR-1:0] d, input int hi, input int lo);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        repeat (hi) @(negedge clk);
        vs_udr = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic uir_pulse(input int hi, input int lo);
        vs_uir = 1'b1;
        repeat (hi) @(negedge clk);
        vs_uir = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Rise applied before edge j: cmd_valid after edge j+3, decode pulse after edge j+4.
    task automatic single_cmd(input logic [IR-1:0] ir, input logic [SR-1:0] d,
                              input logic [3:0] exp_ta, input logic [3:0] exp_tna);
        cmd_ready = 1'b1;
        ir_in = ir;
        sr = d;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        chk("single_valid_early", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        chk("single_valid", 64'(cmd_valid), 64'd1);
        chk("single_ir", 64'(cmd_ir), 64'(ir));
        chk("single_data", 64'(cmd_data), 64'(d));
        vs_udr = 1'b0;
        @(negedge clk);
        chk("single_take_action", 64'(take_action), 64'(exp_ta));
        chk("single_take_no_action", 64'(take_no_action), 64'(exp_tna));
        chk("single_level_after", 64'(fifo_level), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    logic [SR-1:0] fd[5];
    logic [SR-1:0] nd;
    logic [SR-1:0] d;
    logic [3:0]    oh;
    int            cnt;

    initial begin
        reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(cmd_valid), 64'd0);
        chk("reset_level", 64'(fifo_level), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_takes", 64'({take_action, take_no_action}), 64'd0);
        chk("reset_ir_change", 64'(ir_change), 64'd0);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (6) @(negedge clk);

        // Single command: 38'h2_0000_0ABC has bit 37 clear, 38'h20_0000_0ABC has it set.
        single_cmd(2'd2, 38'h2_0000_0ABC, 4'b0000, 4'b0100);
        single_cmd(2'd2, 38'h20_0000_0ABC, 4'b0100, 4'b0000);

        // Fill with the consumer stalled: fifth command is dropped.
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fd[i] = rand38();
            udr_pulse(IR'(i), fd[i], 4, 4);
        end
        chk("fill_level", 64'(fifo_level), 64'd4);
        chk("fill_overflow", 64'(overflow), 64'd1);
        chk("fill_head", 64'(cmd_data), 64'(fd[0]));
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("clear_overflow", 64'(overflow), 64'd0);

        // Full queue, push and pop on the same edge.
        nd = rand38();
        ir_in = 2'd3;
        sr = nd;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        chk("fullpop_level", 64'(fifo_level), 64'd4);
        chk("fullpop_overflow", 64'(overflow), 64'd0);
        repeat (3) @(negedge clk);
        cmd_ready = 1'b1;
        chk("drain0", 64'(cmd_data), 64'(fd[1])); @(negedge clk);
        chk("drain1", 64'(cmd_data), 64'(fd[2])); @(negedge clk);
        chk("drain2", 64'(cmd_data), 64'(fd[3])); @(negedge clk);
        chk("drain3", 64'(cmd_data), 64'(nd));    @(negedge clk);
        chk("drain_level", 64'(fifo_level), 64'd0);
        repeat (2) @(negedge clk);

        // Backpressure: head held for 10 clocks with no decode pulses.
        cmd_ready = 1'b0;
        d = rand38();
        udr_pulse(2'd1, d, 4, 4);
        repeat (10) @(negedge clk);
        chk("bp_data", 64'(cmd_data), 64'(d));
        chk("bp_ir", 64'(cmd_ir), 64'd1);
        chk("bp_takes", 64'({take_action, take_no_action}), 64'd0);
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Decode sweep over every IR with the action bit clear then set.
        for (int b = 0; b < 2; b++) begin
            for (int ir = 0; ir < 4; ir++) begin
                d = rand38();
                d[SR-1] = b[0];
                oh = 4'b0001 << ir;
                ir_in = IR'(ir);
                sr = d;
                vs_udr = 1'b1;
                repeat (4) @(negedge clk);
                vs_udr = 1'b0;
                @(negedge clk);
                chk("sweep_take_action", 64'(take_action), b ? 64'(oh) : 64'd0);
                chk("sweep_take_no_action", 64'(take_no_action), b ? 64'd0 : 64'(oh));
                repeat (3) @(negedge clk);
            end
        end

        // Random traffic with random consumer stalls and overflow clears.
        fork
            begin
                for (int n = 0; n < 40; n++)
                    udr_pulse(IR'($urandom_range(0, 3)), rand38(), $urandom_range(4, 6), $urandom_range(3, 8));
            end
            begin
                repeat (3) @(negedge clk);
                for (int m = 0; m < 12; m++) uir_pulse($urandom_range(3, 5), $urandom_range(3, 20));
            end
            begin
                for (int c = 0; c < 650; c++) begin
                    cmd_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                    clear_overflow = ($urandom_range(0, 19) == 0);
                    @(negedge clk);
                end
            end
        join
        cmd_ready = 1'b1;
        clear_overflow = 1'b0;
        repeat (10) @(negedge clk);

        // Reset with three commands queued.
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) udr_pulse(IR'(i), rand38(), 4, 4);
        chk("queued3_level", 64'(fifo_level), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_level", 64'(fifo_level), 64'd0);
        chk("midreset_valid", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_level", 64'(fifo_level), 64'd0);

        // One vs_uir pulse gives exactly one ir_change cycle and no push.
        cnt = 0;
        vs_uir = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) vs_uir = 1'b0;
            @(negedge clk);
            cnt += int'(ir_change);
        end
        chk("ir_change_count", 64'(cnt), 64'd1);
        chk("ir_change_no_push", 64'(fifo_level), 64'd0);

        // vs_udr already high when reset releases must not push.
        @(negedge clk);
        #2 reset_n = 1'b0;
        vs_udr = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (6) @(negedge clk);
        vs_udr = 1'b0;
        repeat (6) @(negedge clk);
        chk("udr_at_release_level", 64'(fifo_level), 64'd0);
        chk("udr_at_release_valid", 64'(cmd_valid), 64'd0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
